decode_stage: RTL

- Registered instruction-decode pipeline stage for the 16-bit ISA, placed between fetch and execute.
- Decodes one instruction per cycle into register indices, an extended immediate, branch condition, control vector and read enables.
- Generalises the combinational decoder:
  - Parametrised immediate width and link register.
  - Valid/ready handshake on both sides.
  - Load-use hazard bubble insertion.
  - Flush.
  - Sticky halt.
  - Saturating bubble counter.

---
 rtl/decode_stage.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// Registered decode stage for the 16-bit ISA: decodes one instruction per cycle,
// inserts a load-use bubble, supports flush and a sticky halt.
module decode_stage #(
   parameter int unsigned DATA_W         = 16,
   parameter int unsigned ADDR_W         = 16,
   parameter int unsigned LINK_REG       = 15,
   parameter int unsigned LOAD_USE_STALL = 1,
   parameter int unsigned CNT_W          = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_if_valid,
   input  logic [15:0]       i_if_instr,
   input  logic [ADDR_W-1:0] i_if_pc,
   output logic              o_if_ready,
   input  logic              i_flush,
   input  logic              i_ex_ready,
   output logic              o_id_valid,
   output logic [ADDR_W-1:0] o_id_pc,
   output logic [3:0]        o_id_opcode,
   output logic [2:0]        o_id_cond,
   output logic [3:0]        o_id_rd,
   output logic [3:0]        o_id_rs,
   output logic [3:0]        o_id_rt,
   output logic [DATA_W-1:0] o_id_imm,
   output logic [5:0]        o_id_ctrl,
   output logic [1:0]        o_id_re,
   output logic              o_halted,
   output logic [CNT_W-1:0]  o_bubble_cnt
);

   logic [3:0]        w_opcode;
   logic [3:0]        w_rd;
   logic [3:0]        w_rs;
   logic [3:0]        w_rt;
   logic [DATA_W-1:0] w_imm;
   logic [5:0]        w_ctrl;
   logic [1:0]        w_re;
   logic              w_src_hit;
   logic              w_hazard;
   logic              w_if_ready;
   logic              w_take;

   logic              r_valid;
   logic [ADDR_W-1:0] r_pc;
   logic [3:0]        r_opcode;
   logic [2:0]        r_cond;
   logic [3:0]        r_rd;
   logic [3:0]        r_rs;
   logic [3:0]        r_rt;
   logic [DATA_W-1:0] r_imm;
   logic [5:0]        r_ctrl;
   logic [1:0]        r_re;
   logic              r_halted;
   logic [CNT_W-1:0]  r_bubble_cnt;

   assign w_opcode = i_if_instr[15:12];

   // Decode the incoming instruction word into indices, immediate and control.
   always_comb begin
      w_rd   = 4'd0;
      w_rs   = 4'd0;
      w_rt   = 4'd0;
      w_imm  = '0;
      w_ctrl = 6'b000000;
      w_re   = 2'b00;
      case (w_opcode)
         4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin
            w_rd   = i_if_instr[11:8];
            w_rs   = i_if_instr[7:4];
            w_rt   = i_if_instr[3:0];
            w_ctrl = 6'b000010;
            w_re   = 2'b11;
         end
         4'h5, 4'h6, 4'h7: begin
            w_rd   = i_if_instr[11:8];
            w_rs   = i_if_instr[7:4];
            w_imm  = {{(DATA_W-4){1'b0}}, i_if_instr[3:0]};
            w_ctrl = 6'b000010;
            w_re   = 2'b01;
         end
         4'h8: begin
            w_rd   = i_if_instr[11:8];
            w_rs   = i_if_instr[7:4];
            w_imm  = {{(DATA_W-4){i_if_instr[3]}}, i_if_instr[3:0]};
            w_ctrl = 6'b010110;
            w_re   = 2'b01;
         end
         4'h9: begin
            // Store data register lives in the rd field position.
            w_rs   = i_if_instr[7:4];
            w_rt   = i_if_instr[11:8];
            w_imm  = {{(DATA_W-4){i_if_instr[3]}}, i_if_instr[3:0]};
            w_ctrl = 6'b001000;
            w_re   = 2'b11;
         end
         4'hA: begin
            // LHB reads its destination to preserve the low byte.
            w_rd   = i_if_instr[11:8];
            w_rs   = i_if_instr[11:8];
            w_imm  = {{(DATA_W-8){1'b0}}, i_if_instr[7:0]};
            w_ctrl = 6'b000010;
            w_re   = 2'b01;
         end
         4'hB: begin
            w_rd   = i_if_instr[11:8];
            w_imm  = {{(DATA_W-8){i_if_instr[7]}}, i_if_instr[7:0]};
            w_ctrl = 6'b000010;
         end
         4'hC: begin
            w_imm  = {{(DATA_W-9){i_if_instr[8]}}, i_if_instr[8:0]};
            w_ctrl = 6'b100000;
         end
         4'hD: begin
            w_rd   = 4'(LINK_REG);
            w_imm  = {{(DATA_W-12){i_if_instr[11]}}, i_if_instr[11:0]};
            w_ctrl = 6'b000010;
         end
         4'hE: begin
            w_rs   = i_if_instr[7:4];
            w_ctrl = 6'b100000;
            w_re   = 2'b01;
         end
         default: begin
            w_ctrl = 6'b000001;
         end
      endcase
   end

   // Load-use hazard against the load currently held, plus the upstream ready.
   always_comb begin
      w_src_hit  = (w_re[0] && (w_rs == r_rd)) || (w_re[1] && (w_rt == r_rd));
      w_hazard   = (LOAD_USE_STALL != 0) && r_valid && r_ctrl[4] && (r_rd != 4'd0) && w_src_hit;
      w_if_ready = ~i_flush & ~r_halted & ~(r_valid & r_ctrl[0]) & ~w_hazard &
                   (~r_valid | i_ex_ready);
      w_take     = i_if_valid & w_if_ready;
   end

   // Pipeline register: flush beats accept beats drain; otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid  <= 1'b0;
         r_pc     <= '0;
         r_opcode <= 4'd0;
         r_cond   <= 3'd0;
         r_rd     <= 4'd0;
         r_rs     <= 4'd0;
         r_rt     <= 4'd0;
         r_imm    <= '0;
         r_ctrl   <= 6'd0;
         r_re     <= 2'd0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (w_take) begin
         r_valid  <= 1'b1;
         r_pc     <= i_if_pc;
         r_opcode <= w_opcode;
         r_cond   <= i_if_instr[11:9];
         r_rd     <= w_rd;
         r_rs     <= w_rs;
         r_rt     <= w_rt;
         r_imm    <= w_imm;
         r_ctrl   <= w_ctrl;
         r_re     <= w_re;
      end else if (i_ex_ready) begin
         r_valid <= 1'b0;
      end
   end

   // Sticky halt once HLT is handed over; count bubbles caused by the hazard.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_halted     <= 1'b0;
         r_bubble_cnt <= '0;
      end else if (!i_flush && !w_take && i_ex_ready) begin
         if (r_valid && r_ctrl[0]) begin
            r_halted <= 1'b1;
         end
         if (w_hazard && i_if_valid && (r_bubble_cnt != '1)) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
         end
      end
   end

   assign o_if_ready   = w_if_ready;
   assign o_id_valid   = r_valid;
   assign o_id_pc      = r_pc;
   assign o_id_opcode  = r_opcode;
   assign o_id_cond    = r_cond;
   assign o_id_rd      = r_rd;
   assign o_id_rs      = r_rs;
   assign o_id_rt      = r_rt;
   assign o_id_imm     = r_imm;
   assign o_id_ctrl    = r_ctrl;
   assign o_id_re      = r_re;
   assign o_halted     = r_halted;
   assign o_bubble_cnt = r_bubble_cnt;

endmodule
